// File: rtl/deserializer_align.sv
// D-lane 1:S deserializer with manual bitslip and training-pattern word alignment.
// Emits one D*S-bit word per S beats with a valid strobe, plus lock/fail status.
module deserializer_align #(
  parameter int               D             = 8,
  parameter int               S             = 8,
  parameter bit               MSB_FIRST     = 1'b0,
  parameter logic [D*S-1:0]   TRAIN_PATTERN = (D*S)'(64'hF0E1D2C3B4A59687),
  parameter int               LOCK_COUNT    = 4
) (
  input  logic                 high_speed_clock,
  input  logic                 reset_n,
  input  logic [D-1:0]         data_in,
  input  logic                 bitslip,
  input  logic                 align_en,
  output logic [D*S-1:0]       data_out,
  output logic                 data_valid,
  output logic                 locked,
  output logic                 align_fail,
  output logic [$clog2(S)-1:0] slip_count
);

  localparam int CW  = $clog2(S);
  localparam int HW  = $clog2(S + 1);
  localparam int MW  = $clog2(LOCK_COUNT + 1);
  localparam int SHW = (S - 1) * D;

  localparam logic [CW-1:0] CNT_LAST   = CW'(S - 1);
  localparam logic [HW-1:0] HUNT_MAX   = HW'(S);
  localparam logic [HW-1:0] HUNT_LAST  = HW'(S - 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  // Datapath state
  logic [SHW-1:0]   r_shift;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_slip_cnt;
  logic [D*S-1:0]   r_data_out;
  logic             r_valid;

  // Alignment state
  state_t           r_state,     w_state_nxt;
  logic [MW-1:0]    r_match,     w_match_nxt;
  logic [HW-1:0]    r_hunt,      w_hunt_nxt;
  logic             r_fail,      w_fail_nxt;
  logic             r_auto_slip, w_auto_slip_nxt;

  logic             w_slip_now;
  logic             w_frame;
  logic             w_pattern_hit;
  logic [D*S-1:0]   w_word_lsb;
  logic [D*S-1:0]   w_word;

  // Only S-1 older beats are stored; the current data_in completes the word.
  assign w_word_lsb    = {data_in, r_shift};
  assign w_slip_now    = (bitslip & ~align_en) | r_auto_slip;
  assign w_frame       = (r_cnt == CNT_LAST) & ~w_slip_now;
  assign w_pattern_hit = (w_word == TRAIN_PATTERN);

  // NOTE: every variable driven in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_word = w_word_lsb;
    if (MSB_FIRST) begin
      for (int i = 0; i < S; i++) begin
        w_word[(S-1-i)*D +: D] = w_word_lsb[i*D +: D];
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge high_speed_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_slip_cnt <= '0;
      r_data_out <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_shift <= w_word_lsb[D*S-1:D];
      r_valid <= w_frame;
      if (w_frame) begin
        r_data_out <= w_word;
      end
      // A slip freezes the beat counter, pushing the word boundary one beat later.
      if (w_slip_now) begin
        r_slip_cnt <= (r_slip_cnt == CNT_LAST) ? '0 : r_slip_cnt + 1'b1;
      end else begin
        r_cnt      <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge high_speed_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_match     <= '0;
      r_hunt      <= '0;
      r_fail      <= 1'b0;
      r_auto_slip <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_match     <= w_match_nxt;
      r_hunt      <= w_hunt_nxt;
      r_fail      <= w_fail_nxt;
      r_auto_slip <= w_auto_slip_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_match_nxt     = r_match;
    w_hunt_nxt      = r_hunt;
    w_fail_nxt      = r_fail;
    w_auto_slip_nxt = 1'b0;

    if (!align_en) begin
      // Training off: abandon any search in progress, but keep an achieved lock.
      if ((r_state == ST_HUNT) || (r_state == ST_VERIFY)) begin
        w_state_nxt = ST_IDLE;
      end
      w_match_nxt = '0;
      w_hunt_nxt  = '0;
      w_fail_nxt  = 1'b0;
    end else if (w_frame) begin
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_HUNT;
          w_hunt_nxt  = '0;
        end
        ST_HUNT: begin
          if (w_pattern_hit) begin
            w_hunt_nxt = '0;
            if (LOCK_COUNT == 1) begin
              w_state_nxt = ST_LOCKED;
              w_match_nxt = '0;
            end else begin
              w_state_nxt = ST_VERIFY;
              w_match_nxt = MW'(1);
            end
          end else begin
            w_auto_slip_nxt = 1'b1;
            if (r_hunt != HUNT_MAX) begin
              w_hunt_nxt = r_hunt + 1'b1;
            end
            if (r_hunt >= HUNT_LAST) begin
              w_fail_nxt = 1'b1;
            end
          end
        end
        ST_VERIFY: begin
          if (w_pattern_hit) begin
            if (r_match >= MATCH_LAST) begin
              w_state_nxt = ST_LOCKED;
              w_match_nxt = '0;
            end else begin
              w_match_nxt = r_match + 1'b1;
            end
          end else begin
            w_state_nxt     = ST_HUNT;
            w_match_nxt     = '0;
            w_auto_slip_nxt = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!w_pattern_hit) begin
            w_state_nxt     = ST_HUNT;
            w_auto_slip_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_valid;
  assign locked     = (r_state == ST_LOCKED);
  assign align_fail = r_fail;
  assign slip_count = r_slip_cnt;

endmodule

// File: tb/tb_deserializer_align.sv
// Bench for deserializer_align (D=4, S=4): directed pins plus a randomized run
// checked every cycle against a beat-history model of the alignment rules.
module tb_deserializer_align;

  localparam int D = 4;
  localparam int S = 4;
  localparam int LOCK = 4;
  localparam logic [15:0] PAT_LSB = 16'h4321;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  data_in = '0;
  logic        bitslip = 1'b0;
  logic        align_en = 1'b0;

  logic [15:0] data_out0, data_out1;
  logic        data_valid0, data_valid1;
  logic        locked0, locked1;
  logic        align_fail0, align_fail1;
  logic [1:0]  slip_count0, slip_count1;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  deserializer_align #(.D(D), .S(S), .MSB_FIRST(1'b0), .TRAIN_PATTERN(16'h4321), .LOCK_COUNT(LOCK)) dut0 (
    .high_speed_clock(clk), .reset_n(reset_n), .data_in(data_in), .bitslip(bitslip),
    .align_en(align_en), .data_out(data_out0), .data_valid(data_valid0), .locked(locked0),
    .align_fail(align_fail0), .slip_count(slip_count0));

  deserializer_align #(.D(D), .S(S), .MSB_FIRST(1'b1), .TRAIN_PATTERN(16'h1234), .LOCK_COUNT(LOCK)) dut1 (
    .high_speed_clock(clk), .reset_n(reset_n), .data_in(data_in), .bitslip(bitslip),
    .align_en(align_en), .data_out(data_out1), .data_valid(data_valid1), .locked(locked1),
    .align_fail(align_fail1), .slip_count(slip_count1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Frames fall wherever the count of non-slip cycles since reset is a multiple
  // of S; the word is simply the last S beats seen.
  typedef enum int {M_IDLE, M_HUNT, M_VERIFY, M_LOCKED} mstate_t;
  logic [3:0]  hist[$];
  int          m_nonslip, m_slips, m_match, m_hunt;
  mstate_t     m_state;
  bit          m_fail, m_auto;
  logic [15:0] exp_out0, exp_out1;
  bit          exp_valid;

  function automatic logic [15:0] word_of(input bit msb);
    logic [15:0] w = '0;
    for (int i = 0; i < S; i++) begin
      if (msb) w[(S-1-i)*D +: D] = hist[hist.size()-S+i];
      else     w[i*D +: D]       = hist[hist.size()-S+i];
    end
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_nonslip = 0; m_slips = 0; m_match = 0; m_hunt = 0;
    m_state = M_IDLE; m_fail = 0; m_auto = 0;
    exp_out0 = '0; exp_out1 = '0; exp_valid = 0;
  endtask

  task automatic model_step();
    bit slip, frame, hit, auto_next;
    slip = (bitslip && !align_en) || m_auto;
    hist.push_back(data_in);
    if (hist.size() > S) void'(hist.pop_front());
    frame = 0;
    auto_next = 0;
    if (slip) m_slips = (m_slips + 1) % S;
    else begin
      m_nonslip++;
      frame = (m_nonslip % S) == 0;
    end
    exp_valid = frame;
    if (frame) begin
      exp_out0 = word_of(0);
      exp_out1 = word_of(1);
    end
    hit = (exp_out0 == PAT_LSB);
    if (!align_en) begin
      if (m_state == M_HUNT || m_state == M_VERIFY) m_state = M_IDLE;
      m_fail = 0; m_hunt = 0; m_match = 0;
    end else if (frame) begin
      case (m_state)
        M_IDLE: begin m_state = M_HUNT; m_hunt = 0; end
        M_HUNT:
          if (hit) begin m_hunt = 0; m_state = M_VERIFY; m_match = 1; end
          else begin
            auto_next = 1; m_hunt++;
            if (m_hunt >= S) m_fail = 1;
          end
        M_VERIFY:
          if (hit) begin
            m_match++;
            if (m_match >= LOCK) begin m_state = M_LOCKED; m_match = 0; end
          end else begin m_state = M_HUNT; m_match = 0; auto_next = 1; end
        M_LOCKED:
          if (!hit) begin m_state = M_HUNT; auto_next = 1; end
        default: m_state = M_IDLE;
      endcase
    end
    m_auto = auto_next;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en && reset_n) begin
        check("cyc data_out0", data_out0, exp_out0);
        check("cyc data_out1", data_out1, exp_out1);
        check("cyc valid0", data_valid0, exp_valid);
        check("cyc valid1", data_valid1, exp_valid);
        check("cyc locked0", locked0, m_state == M_LOCKED);
        check("cyc locked1", locked1, m_state == M_LOCKED);
        check("cyc fail0", align_fail0, m_fail);
        check("cyc fail1", align_fail1, m_fail);
        check("cyc slips0", slip_count0, m_slips);
        check("cyc slips1", slip_count1, m_slips);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [3:0] b, input logic s, input logic e);
    data_in = b; bitslip = s; align_en = e;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    data_in = '0; bitslip = 0; align_en = 0;
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  logic [3:0] train_seq [4] = '{4'h3, 4'h4, 4'h1, 4'h2};

  initial begin
    bit found;
    do_reset();
    cmp_en = 1;
    check("reset data_out", data_out0, 16'h0);
    check("reset valid", data_valid0, 0);
    check("reset locked", locked0, 0);
    check("reset fail", align_fail0, 0);
    check("reset slips", slip_count0, 0);

    // Plain assembly, both beat orderings.
    for (int i = 1; i <= 8; i++) begin
      step(4'(i), 0, 0);
      if (i == 3) check("valid before 4th", data_valid0, 0);
      if (i == 4) begin
        check("valid 4th", data_valid0, 1);
        check("word1 lsb", data_out0, 16'h4321);
        check("word1 msb", data_out1, 16'h1234);
      end
      if (i == 5) check("valid one cycle", data_valid0, 0);
      if (i == 8) begin
        check("word2 lsb", data_out0, 16'h8765);
        check("word2 msb", data_out1, 16'h5678);
      end
    end

    // Manual bitslip on beat 3 stretches the first frame to five cycles.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      step(4'(i), i == 3, 0);
      if (i == 4) check("no frame after slip", data_valid0, 0);
      if (i == 5) begin
        check("slip frame valid", data_valid0, 1);
        check("slip frame lsb", data_out0, 16'h5432);
        check("slip frame msb", data_out1, 16'h2345);
        check("slip count 1", slip_count0, 1);
      end
      if (i == 9) check("realigned frame", data_out0, 16'h9876);
    end

    // Training on an offset-2 stream, then one corrupted beat.
    do_reset();
    for (int k = 0; k < 41; k++) begin
      step((k == 35) ? 4'hF : train_seq[k % 4], 0, 1);
      if (k == 28) check("not yet locked", locked0, 0);
      if (k == 29) begin
        check("locked", locked0, 1);
        check("train slips", slip_count0, 2);
      end
      if (k == 36) check("lock holds pre-frame", locked0, 1);
    end
    check("lock lost", locked0, 0);
    check("relock slip", slip_count0, 3);
    for (int k = 0; k < 40; k++) step(4'h0, 0, 0);
    check("no fail when disabled", align_fail0, 0);

    // Absent pattern: fail after S hunt slips, cleared by align_en=0.
    do_reset();
    for (int k = 0; k < 24; k++) begin
      step(4'h0, 0, 1);
      if (k == 21) check("fail not yet", align_fail0, 0);
      if (k == 22) check("fail set", align_fail0, 1);
    end
    check("slips wrap", slip_count0, 0);
    step(4'h0, 0, 0);
    check("fail cleared", align_fail0, 0);

    // Asynchronous reset while outputs are live.
    step(4'h1, 1, 0);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(4'(i + 2), 0, 0);
      found = data_valid0;
    end
    check("valid wait", found, 1);
    #2 reset_n = 0;
    #1;
    check("async data_out", data_out0, 16'h0);
    check("async valid", data_valid0, 0);
    check("async slips", slip_count0, 0);
    check("async locked", locked0, 0);
    @(negedge clk);
    reset_n = 1;
    for (int i = 1; i <= 4; i++) begin
      step(4'(i), 0, 0);
      if (i == 3) check("post reset no early valid", data_valid0, 0);
    end
    check("post reset word", data_out0, 16'h4321);

    // Randomized segments.
    for (int seg = 0; seg < 30; seg++) begin
      bit en, patmode, sl;
      int phase, len;
      logic [3:0] b;
      en = 1'($urandom_range(0, 1));
      patmode = $urandom_range(0, 2) != 0;
      phase = $urandom_range(0, 3);
      len = $urandom_range(40, 90);
      if ($urandom_range(0, 9) == 0) begin
        @(posedge clk);
        #3 reset_n = 0;
        #1 check("rand async reset", data_out0, 16'h0);
        @(negedge clk);
        reset_n = 1;
      end
      for (int c = 0; c < len; c++) begin
        b = patmode ? 4'(((c + phase) % 4) + 1) : 4'($urandom);
        if (patmode && $urandom_range(0, 49) == 0) b = 4'($urandom);
        sl = $urandom_range(0, 7) == 0;
        step(b, sl, en);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deserializer_align.md
Name: deserializer_align

Overview:
Parameterised D-lane, 1:S deserializer with a word-alignment stage, the next generation of the team's plain shift-register deserializer.
- Assembles S consecutive D-bit beats into one D*S-bit word and flags it with a one-cycle valid strobe.
- Supports manual bitslip and automatic training-pattern alignment, with lock and fail status.
- Sits between the DDR/IO capture flops and the parallel-domain logic, in the high-speed clock domain.

Parameters:
D, 8, data_in width (bits per beat), >=1
S, 8, deserialization ratio (beats per word), >=2
MSB_FIRST, 0, 0: first-received beat at data_out[D-1:0]; 1: first-received beat at data_out[D*S-1 -: D]
TRAIN_PATTERN, 64'hF0E1D2C3B4A59687, D*S-bit word expected during training (compared in the data_out ordering)
LOCK_COUNT, 4, consecutive matching words required to declare lock, >=1

Ports:
high_speed_clock  in  1  sole clock; all state changes on rising edge
reset_n  in  1  asynchronous, active-low reset
data_in  in  D  one beat per clock
bitslip  in  1  manual slip request, one slip per high cycle; ignored while align_en=1
align_en  in  1  1 = automatic training alignment active
data_out  out  D*S  assembled word
data_valid  out  1  one-cycle strobe, data_out is new
locked  out  1  alignment achieved
align_fail  out  1  sticky: S slips without any pattern match
slip_count  out  clog2(S)  total slips applied, modulo S

Behaviour:
- Reset (asynchronous, reset_n=0) clears every register:
  - data_out=0, data_valid=0, locked=0, align_fail=0, slip_count=0
  - shift register=0, beat counter cnt=0, match counter=0, hunt-slip counter=0, FSM=IDLE
  - Reset asserted mid-word discards the partial word; no valid strobe is produced for it.
- Shift register: loads every cycle; data_in enters at the MSB end, contents shift right by D (newest beat at top).
- Beat counter: cnt counts 0..S-1 and wraps.
  - slip_now = (bitslip & ~align_en) | auto_slip.
  - When slip_now=1, cnt holds for that cycle and no frame is emitted. This moves the word boundary one beat later; that word spans S+1 beats, and the oldest beat is dropped.
- Frame event: frame = (cnt==S-1) & ~slip_now. On a frame edge:
  - data_out is loaded with the S most recent beats, including the current data_in, reordered per MSB_FIRST.
  - data_valid=1 for exactly the next cycle.
  - With no slips, the first valid appears one cycle after the S-th post-reset sampling edge; period is S cycles.
- slip_count increments (wrapping modulo S) on every applied slip, manual or automatic.
- FSM states, evaluated on frame edges only (except where noted):
  - IDLE (locked=0): align_en=1 -> HUNT; hunt-slip counter=0.
  - HUNT: if word==TRAIN_PATTERN -> VERIFY with match=1; if LOCK_COUNT==1, go directly to LOCKED. If word differs, pulse auto_slip for one cycle and increment the hunt-slip counter; when it reaches S, set align_fail. Hunting continues.
  - VERIFY: match -> match+1; reaching LOCK_COUNT -> LOCKED. Mismatch -> HUNT with auto_slip pulse and match=0.
  - LOCKED (locked=1): align_en=1 and mismatch -> HUNT with auto_slip pulse, locked=0. align_en=0 -> hold LOCKED, no comparison.
  - From any state, align_en=0 (sampled every cycle): HUNT/VERIFY -> IDLE, align_fail cleared, match and hunt-slip counters cleared. LOCKED stays LOCKED.
- auto_slip takes effect the cycle after the frame edge that requested it; at most one slip per frame.
- Manual bitslip held high for N cycles produces N slips.
- Data keeps flowing (data_valid strobes) in every state; alignment never gates the output.

Test Plan:
- D=4, S=4, MSB_FIRST=0: reset, then beats 1,2,3,4,5,6,7,8 -> data_valid pulses after the 4th and 8th beats; data_out=16'h4321 then 16'h8765.
- Same stream, MSB_FIRST=1 -> data_out=16'h1234 then 16'h5678.
- D=4, S=4: one bitslip pulse before beat 3 of a continuous counting stream -> that frame takes 5 cycles, later frames realign one beat later, slip_count=1.
- TRAIN_PATTERN=16'h4321, align_en=1, stream repeating 3,4,1,2 (offset 2) -> 2 auto slips, locked=1 after 4 matching words, slip_count=2.
- Locked, align_en=1, inject one corrupted word -> locked=0, FSM HUNT, one auto slip; align_en=0 with a stream that never matches -> align_fail never set.
- Pattern absent with align_en=1 -> align_fail=1 after 4 slips. Deasserting align_en clears it. Asserting reset_n=0 mid-frame clears all outputs immediately, without waiting for a clock edge.
